conv_window_gen: RTL and testbench

Parametrised sliding-window generator feeding the convolution MAC array. It accepts a raster pixel stream over AXI4-Stream, with all channels of one pixel packed in each beat, and buffers KERNEL_SIZE-1 rows in line RAMs. For each stride-aligned position it emits one complete KxK multi-channel window per beat. Compared with the fixed 3x3 single-channel front end it adds generic K/channels, runtime stride 1/2, frame tracking and config checking.

---
 rtl/conv_window_gen.sv | 187 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Sliding KxK multi-channel window generator over a raster AXI4-Stream pixel feed.
// Optional CONV_FRAME_CHECK_EN adds frame_err and s_axis_last framing checks.

module conv_window_line #(
    parameter int PIX_W = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem [DEPTH];

    // Read-before-write at the same address: dout is the row above, din replaces it.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
    assign dout = mem[addr];
endmodule

module conv_window_gen #(
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_WIDTH   = 1024,
    parameter int DIM_WIDTH   = 11
) (
    input  logic                                              axi_clk,
    input  logic                                              axi_reset,
    input  logic                                              enable,
    input  logic [DIM_WIDTH-1:0]                              cfg_width,
    input  logic [DIM_WIDTH-1:0]                              cfg_height,
    input  logic                                              cfg_stride2,
    output logic                                              cfg_error,
    output logic                                              frame_done,
    output logic                                              busy,
`ifdef CONV_FRAME_CHECK_EN
    output logic                                              frame_err,
`endif
    input  logic                                              s_axis_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                    s_axis_data,
    input  logic                                              s_axis_last,
    output logic                                              s_axis_ready,
    output logic                                              m_axis_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] m_axis_data,
    output logic                                              m_axis_last,
    input  logic                                              m_axis_ready
);
    localparam int K     = KERNEL_SIZE;
    localparam int PIX_W = CHANNELS * DATA_WIDTH;
    localparam int AW    = $clog2(MAX_WIDTH);
    localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] KDIM = DIM_WIDTH'(K);
    localparam logic [DIM_WIDTH-1:0] KM1  = DIM_WIDTH'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [DIM_WIDTH-1:0] width_r, height_r, row, col, last_row, last_col;
    logic                 stride2_r;
    logic [K-1:0][K-1:0][PIX_W-1:0] win;
    logic [K-2:0][PIX_W-1:0]        line_rd;
    logic [K-1:0][PIX_W-1:0]        col_new;

    logic                 pix_acc, emit, at_end, at_last_win, cfg_bad, abort;
    logic [DIM_WIDTH-1:0] row_off, col_off, hgt_span, wid_span, odd_mask;

    // Newest pixel sits at the bottom of the column; line buffers shift up one row.
    assign col_new = {s_axis_data, line_rd};

    for (genvar i = 0; i < K - 1; i++) begin : g_line
        conv_window_line #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .AW(AW)) u_line (
            .clk  (axi_clk),
            .we   (pix_acc),
            .addr (col[AW-1:0]),
            .din  (col_new[i+1]),
            .dout (line_rd[i])
        );
    end

    assign busy         = (state != IDLE);
    assign s_axis_ready = (state == RUN) && (!m_axis_valid || m_axis_ready);
    assign pix_acc      = s_axis_valid && s_axis_ready;
    assign m_axis_data  = win;

    assign row_off     = row - KM1;
    assign col_off     = col - KM1;
    assign emit        = (row >= KM1) && (col >= KM1) && !(stride2_r && (row_off[0] || col_off[0]));
    assign at_end      = (row == height_r - ONE) && (col == width_r - ONE);
    assign at_last_win = (row == last_row) && (col == last_col);

    // Final stride-aligned window offset: round the span down to even for stride 2.
    assign odd_mask = {{(DIM_WIDTH-1){1'b1}}, ~cfg_stride2};
    assign hgt_span = (cfg_height - KDIM) & odd_mask;
    assign wid_span = (cfg_width - KDIM) & odd_mask;
    assign cfg_bad  = (32'(cfg_width) < K) || (32'(cfg_width) > MAX_WIDTH) ||
                      (32'(cfg_height) < K) || (cfg_width == '0);

`ifdef CONV_FRAME_CHECK_EN
    assign abort = s_axis_last && !at_end;
`else
    assign abort = 1'b0;
    logic unused_last;
    assign unused_last = s_axis_last;
`endif

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state        <= IDLE;
            cfg_error    <= 1'b0;
            frame_done   <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            row          <= '0;
            col          <= '0;
            width_r      <= '0;
            height_r     <= '0;
            last_row     <= '0;
            last_col     <= '0;
            stride2_r    <= 1'b0;
            win          <= '0;
`ifdef CONV_FRAME_CHECK_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (m_axis_valid && m_axis_ready) begin
                m_axis_valid <= 1'b0;
                m_axis_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (cfg_bad) begin
                            cfg_error <= 1'b1;
                        end else begin
                            cfg_error <= 1'b0;
                            width_r   <= cfg_width;
                            height_r  <= cfg_height;
                            stride2_r <= cfg_stride2;
                            last_row  <= KM1 + hgt_span;
                            last_col  <= KM1 + wid_span;
                            row       <= '0;
                            col       <= '0;
                            state     <= RUN;
`ifdef CONV_FRAME_CHECK_EN
                            frame_err <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (pix_acc) begin
                        for (int r = 0; r < K; r++) begin
                            win[r] <= {col_new[r], win[r][K-1:1]};
                        end
                        if (emit) begin
                            m_axis_valid <= 1'b1;
                            m_axis_last  <= at_last_win || abort;
                        end
                        if (col == width_r - ONE) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                        if (at_end || abort) state <= DONE;
`ifdef CONV_FRAME_CHECK_EN
                        if (abort || (at_end && !s_axis_last)) frame_err <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    // Hold here until the last window has been taken downstream.
                    if (!m_axis_valid || m_axis_ready) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized scoreboard bench for conv_window_gen; windows are predicted from a
// stored frame image and checked by an independent output monitor.

module tb_conv_window_gen;
    localparam int K = 3, CH = 2, DW = 8, MAXW = 16, DIMW = 11;
    localparam int PW = CH * DW, WW = K * K * PW;

    logic            axi_clk = 1'b0, axi_reset = 1'b1, enable = 1'b0, cfg_stride2 = 1'b0;
    logic [DIMW-1:0] cfg_width = 8, cfg_height = 8;
    logic            cfg_error, frame_done, busy;
    logic            s_axis_valid = 1'b0, s_axis_last = 1'b0, s_axis_ready;
    logic [PW-1:0]   s_axis_data = '0;
    logic            m_axis_valid, m_axis_last, m_axis_ready = 1'b1;
    logic [WW-1:0]   m_axis_data;
`ifdef CONV_FRAME_CHECK_EN
    logic            frame_err;
`endif

    conv_window_gen #(.KERNEL_SIZE(K), .CHANNELS(CH), .DATA_WIDTH(DW),
                      .MAX_WIDTH(MAXW), .DIM_WIDTH(DIMW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .enable(enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride2(cfg_stride2),
        .cfg_error(cfg_error), .frame_done(frame_done), .busy(busy),
`ifdef CONV_FRAME_CHECK_EN
        .frame_err(frame_err),
`endif
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
        .s_axis_ready(s_axis_ready), .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct { logic [WW-1:0] data; logic last; } exp_t;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [PW-1:0] frame [16][16];
    int            n_chk = 0, n_fail = 0, win_cnt = 0, done_cnt = 0;
    logic          rand_ready = 1'b0, first_seen = 1'b0, prev_stall = 1'b0;
    logic [WW-1:0] first_data, prev_data;
    int            fw[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Downstream ready: always 1, or a fair coin per cycle when rand_ready is set.
    initial forever begin
        @(posedge axi_clk); #1;
        m_axis_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor / scoreboard.
    always @(negedge axi_clk) begin
        if (axi_reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold: valid %0b data %h expected held %h", m_axis_valid, m_axis_data, prev_data);
                end
            end
            if (m_axis_valid && !m_axis_ready) begin
                n_chk++;
                if (s_axis_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sready_block: got %0b expected 0", s_axis_ready);
                end
            end
            if (m_axis_valid && m_axis_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_win: got window %h expected none", m_axis_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_axis_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL win_data #%0d: got %h expected %h", win_cnt, m_axis_data, mon_e.data);
                    end
                    n_chk++;
                    if (m_axis_last !== mon_e.last) begin
                        n_fail++;
                        $display("FAIL win_last #%0d: got %0b expected %0b", win_cnt, m_axis_last, mon_e.last);
                    end
                end
                if (!first_seen) first_data <= m_axis_data;
                first_seen <= 1'b1;
                win_cnt++;
            end
            if (frame_done) done_cnt++;
            prev_stall <= m_axis_valid && !m_axis_ready;
            prev_data  <= m_axis_data;
        end
    end

    task automatic fill_frame(input int w, input int h, input bit ramp);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                frame[r][c] = {8'($urandom), ramp ? 8'(c + 8 * r) : 8'($urandom)};
    endtask

    // Expected windows for pixels 0..n_stop in raster order, straight from the frame image.
    task automatic build_exp(input int w, input int h, input int s, input int n_stop,
                             input bit force_last, output int n);
        exp_t e;
        int   last_idx = -1;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r * w + c <= n_stop && r >= K - 1 && c >= K - 1 &&
                    (r - (K - 1)) % (s + 1) == 0 && (c - (K - 1)) % (s + 1) == 0) begin
                    for (int rr = 0; rr < K; rr++)
                        for (int cc = 0; cc < K; cc++)
                            e.data[(rr * K + cc) * PW +: PW] = frame[r - (K - 1) + rr][c - (K - 1) + cc];
                    e.last = 1'b0;
                    exp_q.push_back(e);
                    last_idx = r * w + c;
                    n++;
                end
            end
        end
        if (n > 0 && (n_stop == w * h - 1 || (force_last && last_idx == n_stop))) begin
            e = exp_q.pop_back();
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input int w, input int h, input int s);
        cfg_width   = DIMW'(w);
        cfg_height  = DIMW'(h);
        cfg_stride2 = 1'(s);
        enable      = 1'b1;
        @(posedge axi_clk); #1;
        enable      = 1'b0;
    endtask

    task automatic send_pixels(input int w, input int n_stop, input int last_at, input bit gaps);
        int  to;
        bit  acc;
        for (int idx = 0; idx <= n_stop; idx++) begin
            if (gaps) begin
                s_axis_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge axi_clk); #1; end
            end
            s_axis_valid = 1'b1;
            s_axis_data  = frame[idx / w][idx % w];
            s_axis_last  = (idx == last_at);
            to  = 0;
            acc = 1'b0;
            while (!acc && to < 200) begin
                @(negedge axi_clk);
                acc = s_axis_ready;
                @(posedge axi_clk); #1;
                to++;
            end
            if (!acc) begin
                check("pixel_accept_timeout", idx, -1);
                break;
            end
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int to = 0;
        while (busy && to < 1000) begin @(posedge axi_clk); #1; to++; end
        check("idle_timeout", int'(busy), 0);
        repeat (2) begin @(posedge axi_clk); #1; end
    endtask

    task automatic run_frame(input int w, input int h, input int s, input bit ramp, input bit rnd);
        int n;
        fill_frame(w, h, ramp);
        build_exp(w, h, s, w * h - 1, 1'b0, n);
        win_cnt = 0; done_cnt = 0; first_seen = 1'b0;
        start_frame(w, h, s);
        check("cfg_error_clear", int'(cfg_error), 0);
        check("busy_run", int'(busy), 1);
        rand_ready = rnd;
        send_pixels(w, w * h - 1, w * h - 1, rnd);
        wait_idle();
        rand_ready = 1'b0;
        check("win_count", win_cnt, n);
        check("frame_done_count", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_first_ramp();
        check("first_seen", int'(first_seen), 1);
        for (int i = 0; i < 9; i++)
            check("first_win", int'(first_data[i * PW +: DW]), fw[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, int'(m_axis_valid), 0);
        check({tag, "_m_last"}, int'(m_axis_last), 0);
        check({tag, "_m_data_zero"}, int'(|m_axis_data), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_s_ready"}, int'(s_axis_ready), 0);
        check({tag, "_cfg_error"}, int'(cfg_error), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge axi_clk);
        #1;
        check_idle_outputs("reset");
        axi_reset = 1'b0;
        @(posedge axi_clk); #1;

        // Ramp 8x8, stride 1 then stride 2, full-rate downstream.
        run_frame(8, 8, 0, 1'b1, 1'b0);
        check_first_ramp();
        run_frame(8, 8, 1, 1'b1, 1'b0);
        check_first_ramp();
        // Backpressure with random ready and input gaps.
        run_frame(8, 8, 0, 1'b0, 1'b1);

        // Config rejection: too narrow, too wide, too short.
        start_frame(2, 8, 0);
        check("cfg_narrow_error", int'(cfg_error), 1);
        check("cfg_narrow_busy", int'(busy), 0);
        check("cfg_narrow_sready", int'(s_axis_ready), 0);
        start_frame(MAXW + 1, 8, 0);
        check("cfg_wide_error", int'(cfg_error), 1);
        start_frame(8, 2, 0);
        check("cfg_short_error", int'(cfg_error), 1);
        check("cfg_short_busy", int'(busy), 0);
        run_frame(8, 8, 0, 1'b1, 1'b0);

        // Synchronous reset after 30 pixels, then a clean frame.
        fill_frame(8, 8, 1'b1);
        build_exp(8, 8, 0, 29, 1'b0, n);
        start_frame(8, 8, 0);
        send_pixels(8, 29, -1, 1'b0);
        axi_reset = 1'b1;
        @(posedge axi_clk); #1;
        check_idle_outputs("midreset");
        @(posedge axi_clk); #1;
        axi_reset = 1'b0;
        exp_q.delete();
        @(posedge axi_clk); #1;
        run_frame(8, 8, 0, 1'b1, 1'b0);
        check_first_ramp();

        // Boundaries: minimal frame, even spans with stride 2, full line-buffer width.
        run_frame(3, 3, 0, 1'b0, 1'b1);
        run_frame(3, 3, 1, 1'b0, 1'b0);
        run_frame(4, 4, 1, 1'b0, 1'b1);
        run_frame(MAXW, 3, 1, 1'b0, 1'b1);
        run_frame(MAXW, 4, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(3, MAXW), $urandom_range(3, 10), $urandom_range(0, 1), 1'b0, 1'b1);

`ifdef CONV_FRAME_CHECK_EN
        // Early s_axis_last on pixel 42 (row 5, col 2), which completes a window.
        fill_frame(8, 8, 1'b1);
        build_exp(8, 8, 0, 42, 1'b1, n);
        win_cnt = 0; done_cnt = 0;
        start_frame(8, 8, 0);
        send_pixels(8, 42, 42, 1'b0);
        wait_idle();
        check("abort_frame_err", int'(frame_err), 1);
        check("abort_win_count", win_cnt, n);
        check("abort_done", done_cnt, 1);
        check("abort_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        run_frame(8, 8, 0, 1'b1, 1'b0);
        check("next_frame_err_clear", int'(frame_err), 0);
        // Missing s_axis_last on the final pixel: flagged but the frame completes.
        fill_frame(8, 8, 1'b0);
        build_exp(8, 8, 0, 63, 1'b0, n);
        win_cnt = 0; done_cnt = 0;
        start_frame(8, 8, 0);
        send_pixels(8, 63, -1, 1'b0);
        wait_idle();
        check("nolast_frame_err", int'(frame_err), 1);
        check("nolast_win_count", win_cnt, n);
        exp_q.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
